// File: rtl/job_arb_pkg.sv
// Shared types for job_arbiter: arbiter FSM states and job-engine state encodings.
package job_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_KILL   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_ACK    = 3'd5
  } arb_state_e;

  localparam logic [1:0] ENG_IDLE   = 2'd0;
  localparam logic [1:0] ENG_ACTIVE = 2'd1;
  localparam logic [1:0] ENG_FINISH = 2'd2;
  localparam logic [1:0] ENG_ABORT  = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after i_ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_j      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_j = IW'((32'(i_ptr) + i) % N_REQ);
      if (!o_any && i_req[w_j]) begin
        o_any         = 1'b1;
        o_idx         = w_j;
        o_onehot[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/job_arbiter.sv
// Round-robin arbiter sharing one job engine among N_REQ requesters.
// Optional watchdog enabled by defining JOB_ARBITER_WATCHDOG_EN.
module job_arbiter
  import job_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_cancel,
  output logic [N_REQ-1:0] o_grant,
  output logic [N_REQ-1:0] o_ack,
  output logic             o_aborted,
  output logic             o_timeout,
  output logic             o_busy,
  output logic             o_eng_go,
  output logic             o_eng_kill,
  input  logic             i_eng_done,
  input  logic [1:0]       i_eng_state
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("job_arbiter: N_REQ must be in 2..8");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("job_arbiter: TIMEOUT must be >= 2");
  end

  arb_state_e       r_state;
  logic [IW-1:0]    r_owner;
  logic [N_REQ-1:0] r_owner_oh;
  logic [IW-1:0]    r_ptr;
  logic             r_aborted;

  logic [N_REQ-1:0] w_pick_oh;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic             w_owner_cancel;
  logic             w_expired;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_owner_cancel = i_cancel[r_owner];

`ifdef JOB_ARBITER_WATCHDOG_EN
  logic [CW-1:0] r_wdog;
  logic          r_timeout;

  assign w_expired = (r_wdog >= CW'(TIMEOUT - 1));

  // Cleared while launching so every RUN entry starts from zero; saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == ST_LAUNCH) begin
        r_wdog <= '0;
      end else if (r_state == ST_RUN && r_wdog != {CW{1'b1}}) begin
        r_wdog <= r_wdog + CW'(1);
      end
      if (r_state == ST_IDLE) begin
        r_timeout <= 1'b0;
      end else if (r_state == ST_RUN && !i_eng_done && !w_owner_cancel && w_expired) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_timeout = (r_state == ST_ACK) && r_timeout;
`else
  assign w_expired = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_owner_oh <= '0;
      r_ptr      <= '0;
      r_aborted  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_aborted <= 1'b0;
          if (w_pick_any) begin
            r_owner    <= w_pick_idx;
            r_owner_oh <= w_pick_oh;
            r_state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (i_eng_state == ENG_ACTIVE) r_state <= ST_RUN;
        end
        ST_RUN: begin
          // Completion wins over a simultaneous cancel or watchdog expiry.
          if (i_eng_done) begin
            r_aborted <= 1'b0;
            r_state   <= ST_ACK;
          end else if (w_owner_cancel || w_expired) begin
            r_state <= ST_KILL;
          end
        end
        ST_KILL: begin
          if (i_eng_state == ENG_ABORT) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (i_eng_state == ENG_IDLE) begin
            r_aborted <= 1'b1;
            r_state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_ptr   <= (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + IW'(1);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_grant    = o_busy ? r_owner_oh : '0;
  assign o_ack      = (r_state == ST_ACK) ? r_owner_oh : '0;
  assign o_aborted  = (r_state == ST_ACK) && r_aborted;
  assign o_eng_go   = (r_state == ST_LAUNCH);
  assign o_eng_kill = (r_state == ST_KILL);

endmodule

// File: tb/tb_job_arbiter.sv
// Directed self-checking bench for job_arbiter; the engine is driven directly by the stimulus.
module tb_job_arbiter;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned TIMEOUT = 50;
`ifdef JOB_ARBITER_WATCHDOG_EN
  localparam int RUN_LEN = 40;
`else
  localparam int RUN_LEN = 100;
`endif

  logic             clk;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] cancel;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] ack;
  logic             aborted;
  logic             timeout;
  logic             busy;
  logic             eng_go;
  logic             eng_kill;
  logic             eng_done;
  logic [1:0]       eng_state;

  int n_total = 0;
  int n_bad   = 0;

  job_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (req),
    .i_cancel    (cancel),
    .o_grant     (grant),
    .o_ack       (ack),
    .o_aborted   (aborted),
    .o_timeout   (timeout),
    .o_busy      (busy),
    .o_eng_go    (eng_go),
    .o_eng_kill  (eng_kill),
    .i_eng_done  (eng_done),
    .i_eng_state (eng_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full successful job from IDLE with req already driven; ends back in IDLE.
  task automatic do_job(input logic [3:0] exp, input int run_len, input string tag);
    tick();
    check({tag, "_grant"}, 32'(grant), 32'(exp));
    check({tag, "_go"}, 32'(eng_go), 32'd1);
    eng_state = 2'd1;
    tick();
    repeat (run_len - 1) tick();
    eng_state = 2'd2;
    eng_done  = 1'b1;
    tick();
    check({tag, "_ack"}, 32'(ack), 32'(exp));
    check({tag, "_abt"}, 32'(aborted), 32'd0);
    eng_done  = 1'b0;
    eng_state = 2'd0;
    tick();
  endtask

  initial begin
    rst = 1'b1; req = '0; cancel = '0; eng_done = 1'b0; eng_state = 2'd0;
    #3;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_go", 32'(eng_go), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Single request with a long engine run.
    req = 4'b0100;
    tick();
    check("single_grant", 32'(grant), 32'h4);
    check("single_go", 32'(eng_go), 32'd1);
    eng_state = 2'd1;
    tick();
    check("single_go_low", 32'(eng_go), 32'd0);
    repeat (RUN_LEN - 1) tick();
    check("single_nokill", 32'(eng_kill), 32'd0);
    eng_state = 2'd2; eng_done = 1'b1;
    tick();
    check("single_ack", 32'(ack), 32'h4);
    check("single_abt", 32'(aborted), 32'd0);
    check("single_to", 32'(timeout), 32'd0);
    eng_done = 1'b0; eng_state = 2'd0; req = '0;
    tick();
    check("single_idle_ack", 32'(ack), 32'd0);
    check("single_idle_busy", 32'(busy), 32'd0);

    // Fairness from ptr=0.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    req = 4'b1111;
    do_job(4'b0001, 3, "rr0");
    do_job(4'b0010, 3, "rr1");
    do_job(4'b0100, 3, "rr2");
    do_job(4'b1000, 3, "rr3");
    do_job(4'b0001, 3, "rr4");
    req = 4'b1001;
    do_job(4'b1000, 3, "rr5");

    // Cancel from the owner; a non-owner cancel is ignored first. ptr is now 0.
    req = 4'b0010;
    tick();
    check("can_grant", 32'(grant), 32'h2);
    eng_state = 2'd1;
    tick();
    cancel = 4'b0001;
    repeat (2) tick();
    check("can_nonowner", 32'(eng_kill), 32'd0);
    cancel = 4'b0010;
    tick();
    check("can_kill", 32'(eng_kill), 32'd1);
    cancel = '0;
    repeat (2) tick();
    check("can_kill_hold", 32'(eng_kill), 32'd1);
    eng_state = 2'd3;
    tick();
    check("can_drain_kill", 32'(eng_kill), 32'd0);
    tick();
    check("can_drain_ack", 32'(ack), 32'd0);
    eng_state = 2'd0;
    tick();
    check("can_ack", 32'(ack), 32'h2);
    check("can_abt", 32'(aborted), 32'd1);
    check("can_to", 32'(timeout), 32'd0);
    req = '0;
    tick();
    check("can_abt_clr", 32'(aborted), 32'd0);

    // Watchdog: ptr is 2, req=0001 wraps to owner 0; 50 RUN cycles before KILL.
    req = 4'b0001;
    tick();
    check("wd_grant", 32'(grant), 32'h1);
    eng_state = 2'd1;
    tick();
    repeat (TIMEOUT - 1) tick();
    check("wd_pre", 32'(eng_kill), 32'd0);
    tick();
`ifdef JOB_ARBITER_WATCHDOG_EN
    check("wd_kill", 32'(eng_kill), 32'd1);
    eng_state = 2'd3;
    tick();
    eng_state = 2'd0;
    tick();
    check("wd_ack", 32'(ack), 32'h1);
    check("wd_abt", 32'(aborted), 32'd1);
    check("wd_to", 32'(timeout), 32'd1);
`else
    check("wd_nokill", 32'(eng_kill), 32'd0);
    repeat (TIMEOUT) tick();
    check("wd_nokill_late", 32'(eng_kill), 32'd0);
    eng_state = 2'd2; eng_done = 1'b1;
    tick();
    check("wd_ack", 32'(ack), 32'h1);
    check("wd_abt", 32'(aborted), 32'd0);
    check("wd_to", 32'(timeout), 32'd0);
    eng_done = 1'b0;
`endif
    eng_state = 2'd0; req = '0;
    tick();

    // Collision: done and owner cancel together; cancel also ignored in LAUNCH. ptr is 1.
    req = 4'b0100;
    cancel = 4'b0100;
    tick();
    check("col_grant", 32'(grant), 32'h4);
    tick();
    check("col_launch_hold", 32'(eng_go), 32'd1);
    eng_state = 2'd1; cancel = '0;
    tick();
    eng_state = 2'd2; eng_done = 1'b1; cancel = 4'b0100;
    tick();
    check("col_ack", 32'(ack), 32'h4);
    check("col_abt", 32'(aborted), 32'd0);
    check("col_kill", 32'(eng_kill), 32'd0);
    eng_done = 1'b0; eng_state = 2'd0; cancel = '0; req = '0;
    tick();

    // Reset mid-RUN; ptr would be 3 without reset, so req=1010 must pick 1.
    req = 4'b1000;
    tick();
    eng_state = 2'd1;
    tick();
    check("rr_run_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rrun_grant", 32'(grant), 32'd0);
    check("rrun_go", 32'(eng_go), 32'd0);
    check("rrun_kill", 32'(eng_kill), 32'd0);
    check("rrun_busy", 32'(busy), 32'd0);
    check("rrun_ack", 32'(ack), 32'd0);
    eng_state = 2'd0; req = 4'b1010;
    tick();
    rst = 1'b0;
    do_job(4'b0010, 2, "post_rst");
    req = 4'b1000;
    do_job(4'b1000, 2, "post_rst2");
    req = '0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/job_arbiter.md
# job_arbiter

Round-robin arbiter and sequencer that shares one job engine among `N_REQ` requesters. The job engine is the go/kill/done counting FSM with states idle/active/finish/abort. The block selects a requester and launches the engine with `eng_go`. It then waits for completion, or forces an abort with `eng_kill` on cancel or watchdog expiry. It returns a one-cycle acknowledge to the owning requester. It sits between the requester ports and the single engine instance.

## Interface
- `N_REQ`, default 4, number of requesters (2..8)
- `TIMEOUT`, default 200, maximum RUN cycles before a forced kill (must be ≥ 2)
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  N_REQ  level request per requester; held until its `ack`
- `cancel`  in  N_REQ  owner requests abort of its running job
- `grant`  out  N_REQ  one-hot current owner; 0 when idle
- `ack`  out  N_REQ  one-cycle completion pulse to owner
- `aborted`  out  1  qualifies `ack`: 1 = job ended via abort
- `timeout`  out  1  qualifies `ack`: 1 = abort was caused by the watchdog
- `busy`  out  1  state ≠ IDLE
- `eng_go`  out  1  engine start
- `eng_kill`  out  1  engine kill
- `eng_done`  in  1  engine completion pulse
- `eng_state`  in  2  engine state: 0 idle, 1 active, 2 finish, 3 abort

## Operation
- States: IDLE, LAUNCH, RUN, KILL, DRAIN, ACK. All outputs are Moore-decoded from registered state, the registered owner index and the registered flags.
- IDLE: if `req` ≠ 0, pick the first set bit at or after `ptr` (wrapping), register it as owner, go to LAUNCH. If no request, stay.
- LAUNCH: `eng_go`=1; when `eng_state`==1, go to RUN. `cancel` is ignored in this state.
- RUN: `eng_done` → ACK with `aborted`=0. Otherwise `cancel[owner]` or watchdog expiry → KILL. `eng_done` has priority when it coincides with either.
- KILL: `eng_kill`=1; when `eng_state`==3, go to DRAIN.
- DRAIN: `eng_kill`=0; when `eng_state`==0, go to ACK with `aborted`=1.
- ACK: `ack[owner]`=1 for exactly one cycle. `ptr` ← (owner+1) mod N_REQ, then go to IDLE.
- `grant` is asserted from LAUNCH through ACK inclusive.
- `req` is not re-sampled after a grant. A `req` still high after `ack` is rearbitrated fairly.
- `cancel` from non-owners is ignored.
- Reset, including mid-job: state IDLE, `ptr`=0, flags cleared. All outputs are 0 immediately, since the reset is asynchronous. The engine shares `rst`.

## Timing
- `req` sampled in IDLE at cycle k → `grant` and `eng_go` at k+1.
- `eng_done` at cycle t → `ack` at t+1 → IDLE at t+2 → next `eng_go` at t+3 at the earliest.
- Watchdog counter clears on entry to RUN and increments each RUN cycle. KILL is entered on the cycle after the count reaches TIMEOUT−1. The counter is ⌈log2(TIMEOUT+1)⌉ bits and saturates.
- `aborted` and `timeout` are valid only while `ack` is high; they are 0 otherwise.

## Configuration
- `JOB_ARBITER_WATCHDOG_EN` defined: the watchdog counter is present. Expiry forces KILL and sets `timeout`=1 on the resulting `ack`.
- Undefined: no counter. RUN exits only on `eng_done` or `cancel[owner]`. `timeout` is tied to 0 and `TIMEOUT` is unused.

## Structure
- `job_arb_pkg`: arbiter state enum, and engine-state constants `ENG_IDLE`=0, `ENG_ACTIVE`=1, `ENG_FINISH`=2, `ENG_ABORT`=3.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are `req` and `ptr`; outputs are one-hot winner, winner index and `any`.

## Test plan
- Single request: `req`=4'b0100, engine active 100 cycles → `grant`=4'b0100 and `eng_go` 1 cycle after `req`; `ack[2]` 1 cycle after `eng_done`; `aborted`=0.
- Fairness: `req`=4'b1111 held, `ptr`=0 → grant order 0,1,2,3,0; `req`=4'b1001 after owner 0 → next grant 3.
- Cancel: `cancel[1]` in RUN → `eng_kill` high until `eng_state`=3; `ack[1]` with `aborted`=1 one cycle after `eng_state` returns to 0.
- Watchdog (macro on, `TIMEOUT`=50): engine held active → KILL after 50 RUN cycles; `ack` with `aborted`=1 and `timeout`=1. With the macro off, there is no kill.
- Collision: `eng_done` and `cancel[owner]` in the same cycle → `ack` with `aborted`=0; `eng_kill` never asserted.
- Reset in RUN: `rst` pulse → `grant`, `eng_go`, `eng_kill`, `busy` and `ack` are 0 immediately. After release, `req`=4'b0010 is granted with `ptr`=0.
